instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's immediate decode path: packs a format code, register indices, funct fields and a 32-bit signed/raw immediate into one RV32I instruction word.
- Used by the self-test instruction generator and by the bench's stimulus engine to place instructions into instruction memory.
- Two-stage valid/ready pipeline with full backpressure.
- Optional representability checking of the immediate.

Parameters:
- NOP_WORD, 32'h0000_0013, word emitted for an illegal format code (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request carries valid fields
- in_ready  output  1  encoder accepts the request this cycle
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- in_opcode  input  7  placed at [6:0]
- in_rd  input  5  placed at [11:7] for R/I/U/J
- in_rs1  input  5  placed at [19:15] for R/I/S/B
- in_rs2  input  5  placed at [24:20] for R/S/B
- in_funct3  input  3  placed at [14:12] for R/I/S/B
- in_funct7  input  7  placed at [31:25] for R only
- in_imm  input  32  immediate as the decoder would produce it (sign-extended; U carries imm[31:12] with low 12 bits zero)
- out_valid  output  1  encoded word available
- out_ready  input  1  consumer accepts the word
- out_instr  output  32  encoded instruction
- out_err  output  1  immediate not representable, or illegal format

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_instr=0, out_err=0, both stage valids=0. in_ready goes high in the first cycle after release.
- A reset mid-operation discards every in-flight word. Nothing partial is emitted.
- Stage 1 registers the raw fields on accept (in_valid && in_ready).
- Stage 2 registers the packed word and err.
- Latency: accept in cycle N gives out_valid in cycle N+2 when not stalled.
- Advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads.
- Throughput is one word per cycle.
- Simultaneous accept and drain in the same cycle is legal and loses nothing.
- While out_valid && !out_ready, out_instr and out_err hold stable.
- Packing rules:
  - R: funct7, rs2, rs1, funct3, rd, opcode. in_imm is ignored.
  - I: imm[11:0] goes to [31:20].
  - S: imm[11:5] goes to [31:25]; imm[4:0] goes to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - U: imm[31:12] goes to [31:12].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
  - Fields not used by a format are zero. Immediate bits not placed are dropped (truncation).
- Illegal fmt (6 or 7): out_instr=NOP_WORD and out_err=1, regardless of the macro.
- out_err is produced combinationally from stage-1 contents and registered into stage 2 alongside the word.

Optional Feature:
- Macro: INSTR_ENCODER_IMM_CHECK_EN.
- With the macro defined, out_err=1 for a legal format whose immediate does not survive encode→decode:
  - I/S: in_imm[31:11] are not all equal.
  - B: in_imm[31:12] are not all equal, or in_imm[0]=1.
  - U: in_imm[11:0] != 0.
  - J: in_imm[31:20] are not all equal, or in_imm[0]=1.
  - R never flags.
- In the error case the word is still packed by truncation. Timing and handshake are unchanged.
- Without the macro, out_err flags only illegal formats.

Test Plan:
- Reset then a single I request (fmt=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF) → two cycles later out_instr=0xFFF00093, out_err=0.
- S request (opcode=0x23, f3=2, rs1=1, rs2=2, imm=0xFFFFFFFC) → 0xFE20AE23.
- B request (opcode=0x63, imm=8, other fields 0) → 0x00000463.
- J request (opcode=0x6F, rd=1, imm=0x800) → 0x001000EF.
- U request (opcode=0x37, rd=5, imm=0x12345000) → 0x123452B7.
- Back-to-back stream of 4 words with out_ready low for 3 cycles:
  - in_ready drops after 2 accepts.
  - Order is preserved and no word is lost or duplicated.
  - fmt=7 → NOP_WORD with out_err=1.
  - With the macro: B imm=7 gives out_err=1 and I imm=0x800 gives out_err=1; without it both give out_err=0.
  - Asserting rst_n low mid-stream clears out_valid immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs format, register, funct and immediate fields into one word
// through a two-stage valid/ready pipeline. Define INSTR_ENCODER_IMM_CHECK_EN to flag unrepresentable immediates.
module instr_encoder #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err
);

   logic        s1_valid_q;
   logic [2:0]  fmt_q;
   logic [6:0]  opcode_q;
   logic [4:0]  rd_q;
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic [2:0]  funct3_q;
   logic [6:0]  funct7_q;
   logic [31:0] imm_q;

   logic        s2_valid_q;
   logic [31:0] instr_q;
   logic        err_q;

   logic        s1_load;
   logic        s2_load;
   logic [31:0] instr_d;
   logic        err_d;

   assign s2_load   = !s2_valid_q || out_ready;
   assign s1_load   = !s1_valid_q || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid_q;
   assign out_instr = instr_q;
   assign out_err   = err_q;

   always_comb begin
      instr_d = '0;
      err_d   = 1'b0;
      case (fmt_q)
         3'd0: instr_d = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
         3'd1: begin
            instr_d = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            err_d = !((&imm_q[31:11]) || (~|imm_q[31:11]));
`endif
         end
         3'd2: begin
            instr_d = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            err_d = !((&imm_q[31:11]) || (~|imm_q[31:11]));
`endif
         end
         3'd3: begin
            instr_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                       imm_q[4:1], imm_q[11], opcode_q};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            err_d = !((&imm_q[31:12]) || (~|imm_q[31:12])) || imm_q[0];
`endif
         end
         3'd4: begin
            instr_d = {imm_q[31:12], rd_q, opcode_q};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            err_d = |imm_q[11:0];
`endif
         end
         3'd5: begin
            instr_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            err_d = !((&imm_q[31:20]) || (~|imm_q[31:20])) || imm_q[0];
`endif
         end
         default: begin
            instr_d = NOP_WORD;
            err_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         fmt_q      <= '0;
         opcode_q   <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         funct3_q   <= '0;
         funct7_q   <= '0;
         imm_q      <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            fmt_q    <= in_fmt;
            opcode_q <= in_opcode;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            funct3_q <= in_funct3;
            funct7_q <= in_funct7;
            imm_q    <= in_imm;
         end
      end
   end

   // Word and err only update on a real transfer so a stalled output holds stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         instr_q    <= '0;
         err_q      <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            instr_q <= instr_d;
            err_q   <= err_d;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; honours INSTR_ENCODER_IMM_CHECK_EN for expected err.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err)
   );

   task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      in_fmt    = fmt;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = f7;
      in_imm    = imm;
   endtask

   // Sends the driven fields as one request with out_ready high; lat = -1 on timeout.
   task automatic run_one(output logic [31:0] instr, output logic err, output int lat);
      int w;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      w = 0;
      while (!in_ready && w < 10) begin
         @(posedge clk); #1; w++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      instr = out_instr;
      err   = out_err;
      if (!out_valid) lat = -1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      #12;
      chk_cnt++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0)
         $display("FAIL reset_state: valid=%b instr=%h err=%b required 0/00000000/0", out_valid, out_instr, out_err);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
      else pass_cnt++;
      $display("reset: valid=%b instr=%h err=%b in_ready=%b", out_valid, out_instr, out_err, in_ready);
   endtask

   task automatic test_formats();
      logic [31:0] exp_w [5] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'h001000EF, 32'h123452B7};
      logic [31:0] w;
      logic        e;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
            1: drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC);
            2: drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008);
            3: drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
            default: drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
         endcase
         run_one(w, e, lat);
         chk_cnt++;
         if (lat < 0 || w !== exp_w[i] || e !== 1'b0)
            $display("FAIL fmt_%0d: instr=%h err=%b lat=%0d required %h err=0", in_fmt, w, e, lat, exp_w[i]);
         else pass_cnt++;
         $display("fmt %0d: instr=%h err=%b", in_fmt, w, e);
         if (i == 0) begin
            chk_cnt++;
            if (lat !== 1) $display("FAIL latency: extra edges=%0d required 1 (out_valid at N+2)", lat);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_r_and_illegal();
      logic [31:0] w;
      logic        e;
      int          lat;
      drive(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'hFFFFFFFF);
      run_one(w, e, lat);
      chk_cnt++;
      if (lat < 0 || w !== 32'h405201B3 || e !== 1'b0)
         $display("FAIL fmt_r: instr=%h err=%b required 405201b3 err=0", w, e);
      else pass_cnt++;
      $display("fmt R: instr=%h err=%b", w, e);
      drive(3'd6, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'h1);
      run_one(w, e, lat);
      chk_cnt++;
      if (lat < 0 || w !== 32'h00000013 || e !== 1'b1)
         $display("FAIL fmt_illegal6: instr=%h err=%b required 00000013 err=1", w, e);
      else pass_cnt++;
      $display("fmt 6: instr=%h err=%b", w, e);
   endtask

   task automatic test_imm_check();
      logic [31:0] w;
      logic        e;
      int          lat;
      logic        exp_e;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
      exp_e = 1'b1;
`else
      exp_e = 1'b0;
`endif
      drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000007);
      run_one(w, e, lat);
      chk_cnt++;
      if (lat < 0 || w !== 32'h00000363 || e !== exp_e)
         $display("FAIL imm_b7: instr=%h err=%b required 00000363 err=%b", w, e, exp_e);
      else pass_cnt++;
      $display("B imm=7: instr=%h err=%b", w, e);
      drive(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
      run_one(w, e, lat);
      chk_cnt++;
      if (lat < 0 || w !== 32'h80000013 || e !== exp_e)
         $display("FAIL imm_i800: instr=%h err=%b required 80000013 err=%b", w, e, exp_e);
      else pass_cnt++;
      $display("I imm=0x800: instr=%h err=%b", w, e);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [4] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000013, 32'h123452B7};
      logic        exp_e [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] got_w [4];
      logic        got_e [4];
      int          k = 0;
      int          n = 0;
      int          accepts = 0;
      logic        rdy_s, vld_s, ordy_s;
      logic [31:0] prev_w = '0;
      logic        stall_prev = 1'b0;
      int          stall_bad = 0;
      for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
         out_ready = (cyc >= 3);
         in_valid  = (k < 4);
         case (k)
            0: drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
            1: drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC);
            2: drive(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'h0);
            default: drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
         endcase
         #1;
         rdy_s = in_ready; vld_s = out_valid; ordy_s = out_ready;
         if (cyc == 2) begin
            chk_cnt++;
            if (rdy_s !== 1'b0 || accepts != 2)
               $display("FAIL b2b_in_ready_drop: in_ready=%b accepts=%0d required 0 after 2", rdy_s, accepts);
            else pass_cnt++;
         end
         if (stall_prev && vld_s && out_instr !== prev_w) stall_bad++;
         stall_prev = vld_s && !ordy_s;
         prev_w = out_instr;
         if (vld_s && ordy_s) begin
            got_w[n] = out_instr; got_e[n] = out_err; n++;
         end
         @(posedge clk); #1;
         if (in_valid && rdy_s) begin k++; accepts++; end
      end
      in_valid = 1'b0;
      chk_cnt++;
      if (n != 4 || k != 4) $display("FAIL b2b_count: received=%0d accepted=%0d required 4/4", n, k);
      else pass_cnt++;
      chk_cnt++;
      if (stall_bad != 0) $display("FAIL b2b_stall_hold: changes=%0d required 0", stall_bad);
      else pass_cnt++;
      for (int i = 0; i < n; i++) begin
         chk_cnt++;
         if (got_w[i] !== exp_w[i] || got_e[i] !== exp_e[i])
            $display("FAIL b2b_word_%0d: instr=%h err=%b required %h err=%b", i, got_w[i], got_e[i], exp_w[i], exp_e[i]);
         else pass_cnt++;
         $display("b2b word %0d: instr=%h err=%b", i, got_w[i], got_e[i]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      @(posedge clk); #1;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_cnt++;
      if (out_valid !== 1'b1) $display("FAIL rst_mid_setup: out_valid=%b required 1", out_valid);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0)
         $display("FAIL rst_mid_clear: valid=%b instr=%h err=%b required 0/00000000/0", out_valid, out_instr, out_err);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk_cnt++;
      if (seen != 0) $display("FAIL rst_mid_flush: words after reset=%0d required 0", seen);
      else pass_cnt++;
      $display("reset mid-stream: words after release=%0d", seen);
   endtask

   initial begin
      test_reset();
      test_formats();
      test_r_and_illegal();
      test_imm_check();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
